// File: rtl/ccm_ctrl_if.sv
// Core-side request/response and SRAM port bundle for the CCM controller.
// The slave modport is the controller; master is the core plus SRAM environment.
interface ccm_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cntlr_rd;
  logic [ADDR_WIDTH-1:0] cntlr_raddr;
  logic [DATA_WIDTH-1:0] cntlr_rd_data;
  logic                  cntlr_rd_valid;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;

  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport slave (
    input  cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, mem_rd_data,
    output cntlr_rd_data, cntlr_rd_valid, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );

  modport master (
    output cntlr_rd, cntlr_raddr, cntlr_wr, cntlr_waddr, cntlr_wr_data, mem_rd_data,
    input  cntlr_rd_data, cntlr_rd_valid, mem_rd, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/ccm_ctrl.sv
// CCM controller: passes requests straight to a registered-output SRAM and returns read
// data one cycle later, forwarding same-cycle write data when a read collides with it.
module ccm_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  ccm_ctrl_if.slave   bus
);

  logic                  rd_pend_d,  rd_pend_q;
  logic                  fwd_hit_d,  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_d, fwd_data_q;
  logic [DATA_WIDTH-1:0] rd_hold_d,  rd_hold_q;
  logic [DATA_WIDTH-1:0] rd_ret;
  logic                  collide;

  // Requests are gated by reset so nothing reaches the SRAM while held in reset.
  assign bus.mem_rd      = bus.cntlr_rd & rst_n;
  assign bus.mem_rd_addr = bus.cntlr_raddr;
  assign bus.mem_wr      = bus.cntlr_wr & rst_n;
  assign bus.mem_wr_addr = bus.cntlr_waddr;
  assign bus.mem_wr_data = bus.cntlr_wr_data;

  // The SRAM returns old contents on a same-edge read/write, so remember the new word.
  assign collide = bus.cntlr_rd & bus.cntlr_wr & (bus.cntlr_raddr == bus.cntlr_waddr);

  always_comb begin
    rd_ret = fwd_hit_q ? fwd_data_q : bus.mem_rd_data;
  end

  always_comb begin
    rd_pend_d  = bus.cntlr_rd;
    fwd_hit_d  = collide;
    fwd_data_d = fwd_data_q;
    rd_hold_d  = rd_hold_q;
    if (collide) begin
      fwd_data_d = bus.cntlr_wr_data;
    end
    if (rd_pend_q) begin
      rd_hold_d = rd_ret;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  always_comb begin
    bus.cntlr_rd_valid = rd_pend_q;
    bus.cntlr_rd_data  = rd_pend_q ? rd_ret : rd_hold_q;
  end

endmodule

// File: tb/tb_ccm_ctrl.sv
// Bench for ccm_ctrl: behavioural SRAM, table of directed vectors with fixed expected
// results, and a read scoreboard fed from a shadow memory model.
module tb_ccm_ctrl;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ccm_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ccm_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM: registered read port, write port, read returns old data on collision.
  logic [DW-1:0] sram [2**AW];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rd_data <= sram[bus.mem_rd_addr];
    if (bus.mem_wr) sram[bus.mem_wr_addr] <= bus.mem_wr_data;
  end

  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          rst;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic r, input logic rd, input int ra, input logic wr,
                              input int wa, input logic [DW-1:0] wd, input logic ev,
                              input logic [DW-1:0] ed);
    vec_t v;
    v.rst = r; v.rd = rd; v.raddr = AW'(ra); v.wr = wr; v.waddr = AW'(wa); v.wdata = wd;
    v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check request path, then check the return after posedge.
  task automatic step(input logic r, input logic rd, input logic [AW-1:0] ra, input logic wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] e;
    @(negedge clk);
    rst_n = r;
    bus.cntlr_rd = rd; bus.cntlr_raddr = ra;
    bus.cntlr_wr = wr; bus.cntlr_waddr = wa; bus.cntlr_wr_data = wd;
    if (r && rd) begin
      e = (wr && wa == ra) ? wd : ref_mem[ra];
      sb.push_back(e);
    end
    if (r && wr) ref_mem[wa] = wd;
    #1;
    chk("mem_rd", {31'd0, bus.mem_rd}, {31'd0, r & rd});
    chk("mem_wr", {31'd0, bus.mem_wr}, {31'd0, r & wr});
    if (r && rd) chk("mem_rd_addr", {21'd0, bus.mem_rd_addr}, {21'd0, ra});
    if (r && wr) begin
      chk("mem_wr_addr", {21'd0, bus.mem_wr_addr}, {21'd0, wa});
      chk("mem_wr_data", bus.mem_wr_data, wd);
    end
    @(posedge clk);
    #1;
    if (bus.cntlr_rd_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected_valid: got valid=1 expected valid=0");
      end else begin
        e = sb.pop_front();
        chk("sb_rd_data", bus.cntlr_rd_data, e);
      end
    end else if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_missing_valid: got valid=0 expected valid=1");
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    bus.cntlr_rd = 1'b0; bus.cntlr_raddr = '0;
    bus.cntlr_wr = 1'b0; bus.cntlr_waddr = '0; bus.cntlr_wr_data = '0;
    bus.mem_rd_data = '0;

    // Reset with a write held active, then read address 5 back.
    vecs.push_back(mk(0, 0, 0,    1, 5,    32'h1234,     0, 32'h0));
    vecs.push_back(mk(0, 0, 0,    1, 5,    32'h1234,     0, 32'h0));
    vecs.push_back(mk(1, 1, 5,    0, 0,    32'h0,        1, 32'h0));
    // Write 10 twice, idle, read, idle (hold).
    vecs.push_back(mk(1, 0, 0,    1, 10,   32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0,    1, 10,   32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0,    0, 0,    32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1, 10,   0, 0,    32'h0,        1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 0,    0, 0,    32'h0,        0, 32'hDEADBEEF));
    // Collision forwarding on 20.
    vecs.push_back(mk(1, 1, 20,   1, 20,   32'hCAFEF00D, 1, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 0,    0, 0,    32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 20,   0, 0,    32'h0,        1, 32'hCAFEF00D));
    // Back-to-back writes then reads.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 1, i, 32'hA0 + i, 0, 32'hCAFEF00D));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, i, 0, 0, 32'h0, 1, 32'hA0 + i));
    // Top address, write then read next cycle; address 0 unaffected.
    vecs.push_back(mk(1, 0, 0,    1, 2047, 32'hFFFF0000, 0, 32'hA3));
    vecs.push_back(mk(1, 1, 2047, 0, 0,    32'h0,        1, 32'hFFFF0000));
    vecs.push_back(mk(1, 1, 0,    0, 0,    32'h0,        1, 32'hA0));
    // Independent read and write to different addresses in one cycle.
    vecs.push_back(mk(1, 1, 2,    1, 1,    32'h55,       1, 32'hA2));
    vecs.push_back(mk(1, 1, 1,    0, 0,    32'h0,        1, 32'h55));
    // Read then reset: pending valid and hold are cleared; memory survives.
    vecs.push_back(mk(1, 1, 10,   0, 0,    32'h0,        1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 10,   0, 0,    32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0,    0, 0,    32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1, 10,   0, 0,    32'h0,        1, 32'hDEADBEEF));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.cntlr_rd_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), bus.cntlr_rd_data, vecs[i].exp_data);
    end

    // Random pipelined traffic on a small address window to force frequent collisions.
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom());
    end
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, '0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
